// File: rtl/sm_result_unpack.sv
// sm_result_unpack: converts 36-bit sign-magnitude result words to two's
// complement, flags full-scale (saturated) magnitudes, and buffers the
// converted words in a DEPTH-entry FIFO with valid/ready handshakes on both
// sides. A 16-bit sticky counter tallies saturated words accepted.
module sm_result_unpack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [35:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [35:0] data_out,
  output logic        sat_out,
  input  logic        clr_cnt,
  output logic [15:0] sat_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic               sat;
    logic signed [35:0] val;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           rdy_en_q, rdy_en_d;
  logic [15:0]    sat_cnt_q, sat_cnt_d;

  logic           push, pop;
  entry_t         wr_entry;
  entry_t         head;

  // Sign-magnitude to two's complement; negative zero folds to zero because
  // negating an all-zero value yields zero.
  function automatic logic signed [35:0] sm_to_tc(input logic [35:0] w);
    logic signed [35:0] m;
    m = signed'({1'b0, w[34:0]});
    return w[35] ? -m : m;
  endfunction

  // A word is saturated when its magnitude is full scale, whatever its sign.
  function automatic logic is_sat(input logic [35:0] w);
    return &w[34:0];
  endfunction

  // Saturating increment for the 16-bit event counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (&c) ? c : c + 16'd1;
  endfunction

  assign wr_entry.sat = is_sat(data_in);
  assign wr_entry.val = sm_to_tc(data_in);
  assign head         = mem_q[rptr_q];

  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  // Full FIFO may still take a word when the head leaves in the same cycle.
  assign in_ready  = rdy_en_q & ((cnt_q != FULL_CNT) | pop);
  assign push      = in_valid & in_ready;

  // Outputs are gated to zero when empty so reset and idle show clean zeros.
  assign data_out = out_valid ? head.val : '0;
  assign sat_out  = out_valid & head.sat;
  assign sat_cnt  = sat_cnt_q;

  // Next-state for pointers, occupancy, input enable and saturation counter.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    rdy_en_d  = 1'b1;
    sat_cnt_d = sat_cnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
    if (clr_cnt)                    sat_cnt_d = '0;
    else if (push && wr_entry.sat)  sat_cnt_d = sat_inc16(sat_cnt_q);
  end

  // Control state: async reset empties the FIFO and clears the counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rdy_en_q  <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      rdy_en_q  <= rdy_en_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  // FIFO storage: converted value and saturation flag written as one entry.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_entry;
  end

endmodule

// File: tb/tb_sm_result_unpack.sv
// Testbench for sm_result_unpack: table-driven conversion vectors, a
// scoreboard queue filled on accept and drained on pop, and hand-written
// sequences for backpressure, counter saturation/clear and mid-stream reset.
module tb_sm_result_unpack;

  logic        clk;
  logic        rst_b;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] data_out;
  logic        sat_out;
  logic        clr_cnt;
  logic [15:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [35:0] din;
    logic [35:0] exp_val;
    logic        exp_sat;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [35:0] val;
    logic        sat;
  } sb_t;

  sb_t         sb[$];
  logic [35:0] cur_exp_val;
  logic        cur_exp_sat;

  sm_result_unpack #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .sat_out   (sat_out),
    .clr_cnt   (clr_cnt),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] model_val(input logic [35:0] d);
    logic [35:0] mag;
    mag = {1'b0, d[34:0]};
    return d[35] ? (36'd0 - mag) : mag;
  endfunction

  function automatic logic model_sat(input logic [35:0] d);
    return d[34:0] == 35'h7_FFFF_FFFF;
  endfunction

  // Scoreboard monitor: compare the head whenever valid, pop on handshake,
  // and record the expected result of every accepted word.
  always @(negedge clk) begin
    if (rst_b) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", {35'd0, out_valid}, 36'd0);
        end else begin
          chk("data_out", data_out, sb[0].val);
          chk("sat_out", {35'd0, sat_out}, {35'd0, sb[0].sat});
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) sb.push_back('{val: cur_exp_val, sat: cur_exp_sat});
    end
  end

  // Offer one word and wait (bounded) until it is accepted.
  task automatic send(input logic [35:0] d, input logic [35:0] ev, input logic es);
    logic acc;
    data_in     = d;
    cur_exp_val = ev;
    cur_exp_sat = es;
    in_valid    = 1'b1;
    acc         = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 36'd0, 36'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [35:0] d);
    send(d, model_val(d), model_sat(d));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 36'(sb.size()), 36'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int n;
    vecs[0] = '{36'h0_0000_0005, 36'h0_0000_0005, 1'b0, 16'd0};
    vecs[1] = '{36'h8_0000_0001, 36'hF_FFFF_FFFF, 1'b0, 16'd0};
    vecs[2] = '{36'h8_0000_0000, 36'h0_0000_0000, 1'b0, 16'd0};
    vecs[3] = '{36'hF_FFFF_FFFF, 36'h8_0000_0001, 1'b1, 16'd1};
    vecs[4] = '{36'h7_FFFF_FFFF, 36'h7_FFFF_FFFF, 1'b1, 16'd2};
    vecs[5] = '{36'h0_0000_0000, 36'h0_0000_0000, 1'b0, 16'd2};
    vecs[6] = '{36'h8_0000_1234, 36'hF_FFFF_EDCC, 1'b0, 16'd2};
    vecs[7] = '{36'h7_FFFF_FFFE, 36'h7_FFFF_FFFE, 1'b0, 16'd2};
    vecs[8] = '{36'hF_FFFF_FFFE, 36'h8_0000_0002, 1'b0, 16'd2};

    rst_b       = 1'b0;
    in_valid    = 1'b0;
    data_in     = '0;
    out_ready   = 1'b0;
    clr_cnt     = 1'b0;
    cur_exp_val = '0;
    cur_exp_sat = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", {35'd0, out_valid}, 36'd0);
    chk("rst_data_out", data_out, 36'd0);
    chk("rst_sat_out", {35'd0, sat_out}, 36'd0);
    chk("rst_sat_cnt", {20'd0, sat_cnt}, 36'd0);
    chk("rst_in_ready", {35'd0, in_ready}, 36'd0);
    repeat (3) @(posedge clk);
    #2 rst_b = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", {35'd0, in_ready}, 36'd1);

    // Conversion table
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].din, vecs[i].exp_val, vecs[i].exp_sat);
      chk("sat_cnt_vec", {20'd0, sat_cnt}, {20'd0, vecs[i].exp_cnt});
    end
    drain();

    // Backpressure: four accepts fill the FIFO, fifth waits
    out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) send_m(36'(w));
    data_in     = 36'd5;
    cur_exp_val = model_val(36'd5);
    cur_exp_sat = 1'b0;
    in_valid    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("in_ready_full", {35'd0, in_ready}, 36'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_full_pop", {35'd0, in_ready}, 36'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_occupancy_kept", {35'd0, out_valid}, 36'd1);
    drain();

    // Counter boundary: preload to 16'hFFFE with back-to-back saturated words
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("sat_cnt_clr", {20'd0, sat_cnt}, 36'd0);
    data_in     = 36'hF_FFFF_FFFF;
    cur_exp_val = model_val(36'hF_FFFF_FFFF);
    cur_exp_sat = 1'b1;
    in_valid    = 1'b1;
    n = 0;
    for (int c = 0; c < 70000 && n < 65534; c++) begin
      @(negedge clk);
      if (in_ready) n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("preload_accepts", 36'(n), 36'd65534);
    chk("sat_cnt_fffe", {20'd0, sat_cnt}, {20'd0, 16'hFFFE});
    send_m(36'h7_FFFF_FFFF);
    chk("sat_cnt_ffff", {20'd0, sat_cnt}, {20'd0, 16'hFFFF});
    send_m(36'hF_FFFF_FFFF);
    chk("sat_cnt_hold", {20'd0, sat_cnt}, {20'd0, 16'hFFFF});
    send_m(36'h0_0000_0003);
    chk("sat_cnt_hold_nonsat", {20'd0, sat_cnt}, {20'd0, 16'hFFFF});
    clr_cnt = 1'b1;
    send_m(36'h7_FFFF_FFFF);
    clr_cnt = 1'b0;
    chk("sat_cnt_clr_priority", {20'd0, sat_cnt}, 36'd0);
    drain();

    // Reset mid-stream with three queued words
    out_ready = 1'b0;
    send_m(36'h0_0000_0011);
    send_m(36'hF_FFFF_FFFF);
    send_m(36'h8_0000_0022);
    chk("queued_valid", {35'd0, out_valid}, 36'd1);
    chk("queued_sat_cnt", {20'd0, sat_cnt}, 36'd1);
    #2 rst_b = 1'b0;
    #1;
    sb.delete();
    chk("midrst_out_valid", {35'd0, out_valid}, 36'd0);
    chk("midrst_sat_cnt", {20'd0, sat_cnt}, 36'd0);
    chk("midrst_data_out", data_out, 36'd0);
    chk("midrst_in_ready", {35'd0, in_ready}, 36'd0);
    @(posedge clk); #2;
    rst_b     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("release_in_ready_low", {35'd0, in_ready}, 36'd0);
    @(posedge clk); #1;
    chk("release_in_ready_high", {35'd0, in_ready}, 36'd1);
    repeat (5) begin
      @(negedge clk);
      chk("no_stale_word", {35'd0, out_valid}, 36'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_result_unpack.md
SM_RESULT_UNPACK -- requirements
Module: sm_result_unpack

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries; legal values 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_b, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, producer has a word on data_in.
REQ-005 SHALL have port in_ready, output, 1, block can accept a word this cycle.
REQ-006 SHALL have port data_in, input, 36, sign-magnitude word: bit 35 is the sign, bits 34:0 are the magnitude.
REQ-007 SHALL have port out_valid, output, 1, FIFO head is valid.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts the head.
REQ-009 SHALL have port data_out, output, 36, two's-complement value of the FIFO head.
REQ-010 SHALL have port sat_out, output, 1, head word was saturated.
REQ-011 SHALL have port clr_cnt, input, 1, synchronous clear of sat_cnt.
REQ-012 SHALL have port sat_cnt, output, 16, count of saturated words accepted.

Function
REQ-013 SHALL accept a word on any rising edge where in_valid and in_ready are both 1.
REQ-014 SHALL drive in_ready = 1 when the FIFO holds fewer than DEPTH entries, or when the head is popped in the same cycle.
REQ-015 SHALL convert each word as follows:
- sign 0: data_out = {1'b0, mag}.
- sign 1: data_out = -{1'b0, mag}, computed in 36 bits.
REQ-016 SHALL map negative zero (sign 1, magnitude 0) to 36'd0 with sat_out = 0.
REQ-017 SHALL treat a word as saturated when its magnitude equals 35'h7_ffff_ffff, regardless of sign.
REQ-018 SHALL store the converted value and the saturation flag together as one FIFO entry.
REQ-019 SHALL present a word accepted at edge N on data_out at edge N+1 when the FIFO was empty (latency 1 cycle); otherwise in FIFO order.
REQ-020 SHALL pop the head on an edge where out_valid and out_ready are both 1.
REQ-021 SHALL hold data_out and sat_out stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL, on a simultaneous push and pop when full, keep the occupancy at DEPTH and lose no data.
REQ-023 SHALL, on a simultaneous push and pop when empty, not allow the pushed word to bypass the FIFO; it appears on the next cycle.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH.
REQ-025 SHALL track occupancy in log2(DEPTH)+1 bits.
REQ-026 SHALL increment sat_cnt by 1 for each accepted saturated word.
REQ-027 SHALL hold sat_cnt at 16'hFFFF once it reaches that value (no wrap-around).
REQ-028 SHALL give clr_cnt priority over the increment: when both occur in one cycle, sat_cnt becomes 0.
REQ-029 SHALL make data_out and sat_out don't-care while out_valid = 0; the bench SHALL NOT check them then.

Reset
REQ-030 SHALL, while rst_b = 0, force the following regardless of clk:
- out_valid = 0, data_out = 0, sat_out = 0, sat_cnt = 0.
- FIFO empty, read and write pointers 0.
REQ-031 SHALL drive in_ready = 0 during reset and 1 on the first edge after reset is released.
REQ-032 SHALL discard all FIFO contents when reset is asserted mid-stream; no stale word appears after release.

Verification
REQ-033 SHALL cover positive conversion: data_in = 36'h0_0000_0005 accepted -> next cycle out_valid = 1, data_out = 36'h0_0000_0005, sat_out = 0.
REQ-034 SHALL cover negative conversion and negative zero:
- data_in = 36'h8_0000_0001 -> data_out = 36'hF_FFFF_FFFF.
- data_in = 36'h8_0000_0000 -> data_out = 0.
REQ-035 SHALL cover saturation:
- data_in = 36'hF_FFFF_FFFF -> data_out = 36'h8_0000_0001, sat_out = 1, sat_cnt = 1.
- data_in = 36'h7_FFFF_FFFF -> data_out = 36'h7_FFFF_FFFF, sat_out = 1, sat_cnt = 2.
REQ-036 SHALL cover backpressure (DEPTH = 4):
- out_ready = 0 and 5 words offered -> in_ready drops after 4 accepts.
- out_ready = 1 -> words exit in order 1..4.
- a simultaneous push and pop while full keeps in_ready = 1 and loses no word.
REQ-037 SHALL cover the counter boundary:
- sat_cnt preloaded to 16'hFFFE by driving saturated words -> two more saturated words -> sat_cnt = 16'hFFFF and holds.
- clr_cnt together with a saturated accept -> sat_cnt = 0.
REQ-038 SHALL cover reset mid-stream: 3 words queued, rst_b pulsed low asynchronously -> out_valid = 0 and sat_cnt = 0 immediately; after release, no queued word appears.
